alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, registered successor to the processor's combinational ALU.
- Supports the existing op set: 2-op arith, 1-op arith, ADDI, SUBI, LOAD/STORE address, STC, STB.
- Adds extended 1-op shifts/rotates and an iterative shift-add multiplier.
- Owns the carry and borrow flags as internal state, so the datapath no longer feeds them back in.
- Ops are issued with a start/busy/done handshake; sits between the register-file read stage and writeback.

Parameters:
- DATA_WIDTH, 16: operand/result width; must be >= 4.
- IMM_WIDTH, 6: immediate width; zero-extended to DATA_WIDTH.

Ports:
- clk_pi  in  1  clock.
- reset_pi  in  1  synchronous, active-high reset.
- start_pi  in  1  issue request; sampled only when busy_po=0.
- op_class_pi  in  3  0=ARITH_2OP, 1=ARITH_1OP, 2=ADDI, 3=SUBI, 4=LOAD_OR_STORE, 5=MUL, 6=STC, 7=STB.
- alu_func_pi  in  3  sub-function for classes 0/1.
- reg1_data_pi  in  DATA_WIDTH  operand A.
- reg2_data_pi  in  DATA_WIDTH  operand B.
- immediate_pi  in  IMM_WIDTH  immediate operand.
- busy_po  out  1  high while a MUL is in progress.
- done_po  out  1  one-cycle pulse when result_po/flags are updated.
- alu_result_po  out  DATA_WIDTH  result, or MUL low half.
- alu_result_hi_po  out  DATA_WIDTH  MUL high half; 0 after any non-MUL op.
- carry_out_po  out  1  registered carry flag.
- borrow_out_po  out  1  registered borrow flag.

Behaviour:
- Reset, synchronous, on clk_pi rising edge with reset_pi=1: all outputs and internal state go to 0, FSM to IDLE. Reset wins over start_pi in the same cycle.
- FSM states: IDLE, MUL_RUN.
- Accepting an op: start_pi=1 in IDLE accepts it. start_pi while busy_po=1 is ignored; no queueing.
- Single-cycle classes (0,1,2,3,4,6,7):
  - Operands are captured at the accepting edge.
  - alu_result_po and the flags update at that edge.
  - done_po=1 for the following cycle only.
- ARITH_2OP, full (DATA_WIDTH+1)-bit arithmetic:
  - ADD=000: {carry, res} = A+B.
  - ADDC=001: {carry, res} = A+B+carry.
  - SUB=010: {borrow, res} = A-B; borrow=1 iff A<B.
  - SUBB=011: {borrow, res} = A-B-borrow.
  - AND=100, OR=101, XOR=110, XNOR=111: result only.
- ARITH_1OP (uses A only):
  - 000 NOT.
  - 001 SHL by 1, zero fill.
  - 010 SHR by 1, logical.
  - 011 CP.
  - 100 ASR by 1.
  - 101 ROL by 1.
  - 110 ROR by 1.
  - 111 reserved: result 0, flags held, done still pulses.
- ADDI: {carry, res} = A + zext(imm).
- SUBI: {borrow, res} = A - zext(imm).
- LOAD_OR_STORE: res = A + zext(imm); flags held.
- STC: carry=1. STB: borrow=1. In both, result forced to 0 and the other flag held.
- Flags update only where stated above; all other ops hold both flags. alu_result_hi_po is cleared by every non-MUL op.
- MUL (unsigned A*B, 2*DATA_WIDTH-bit product):
  - Accept captures A and B, clears the accumulator, sets busy_po=1 and enters MUL_RUN.
  - One partial product is added per cycle, DATA_WIDTH iterations.
  - On the final iteration edge: FSM returns to IDLE, busy_po=0, {alu_result_hi_po, alu_result_po} = product, done_po pulses the next cycle.
  - Total latency, accept edge to done_po high: DATA_WIDTH+1 cycles.
  - Flags held.
  - A new start_pi is accepted in the same cycle done_po is high (back-to-back issue).
- Outputs alu_result_po and alu_result_hi_po hold their last value between ops; they are not disturbed during MUL_RUN.
- Reset during MUL_RUN aborts the multiply: no done_po, outputs go to 0.
- Operand changes after the accept edge have no effect.

Optional Feature:
- Macro: ALU_SEQ_ZN_FLAGS_EN.
- When defined:
  - Adds outputs zero_flag_po (1) and negative_flag_po (1), registered alongside alu_result_po.
  - zero=1 iff the result is all zeros; for MUL, iff the full product is zero.
  - negative = MSB of alu_result_po (for MUL, MSB of alu_result_hi_po).
  - Both reset to 0 and update on every done event.
- When undefined: these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Reset, then ADD A=0xFFFF B=0x0001 -> next cycle done_po=1, result=0x0000, carry=1, borrow=0. Then ADDC A=0x0001 B=0x0001 -> result=0x0003, carry=0.
- SUB A=0x0000 B=0x0001 -> result=0xFFFF, borrow=1. SUBB A=0x0005 B=0x0001 -> 0x0003, borrow=0. SUBI A=0x0010 imm=0x3F -> 0xFFD1, borrow=1.
- STC, then AND A=0x00F0 B=0x0FF0 -> result=0x00F0, carry remains 1. ARITH_1OP ASR A=0x8002 -> 0xC001. ROR A=0x0001 -> 0x8000.
- MUL A=0x1234 B=0x0010 -> busy_po high for 16 cycles, done on cycle 17: lo=0x2340, hi=0x0001. A start_pi issuing ADD during busy is ignored. A back-to-back ADD issued on the done cycle is accepted.
- MUL A=0xFFFF B=0xFFFF -> lo=0x0001, hi=0xFFFE, flags unchanged. Following LOAD_OR_STORE A=0x0100 imm=0x04 -> result 0x0104, hi=0x0000.
- Issue MUL, assert reset_pi on the 5th busy cycle -> next cycle busy=0, all outputs 0, no done_po. A simultaneous start_pi+reset_pi is ignored.

Source files
------------

// File: rtl/alu_seq_if.sv
// alu_seq_if: issue/result bundle between the register-file read stage,
// the sequential ALU and writeback.
// Optional zero/negative flag outputs are present only when the macro
// ALU_SEQ_ZN_FLAGS_EN is defined.
//
// Handshake: start_pi is sampled on a rising clock edge only while busy_po=0;
// a sampled start_pi accepts the op and its operands at that edge. done_po is
// a one-cycle pulse marking the cycle in which alu_result_po, alu_result_hi_po
// and the flags carry the result of the op. start_pi seen while busy_po=1 is
// dropped, never queued. A new op may be issued in the done_po cycle.
interface alu_seq_if #(
  parameter int DATA_WIDTH = 16,
  parameter int IMM_WIDTH  = 6
);
  logic                  start_pi;
  logic [2:0]            op_class_pi;
  logic [2:0]            alu_func_pi;
  logic [DATA_WIDTH-1:0] reg1_data_pi;
  logic [DATA_WIDTH-1:0] reg2_data_pi;
  logic [IMM_WIDTH-1:0]  immediate_pi;
  logic                  busy_po;
  logic                  done_po;
  logic [DATA_WIDTH-1:0] alu_result_po;
  logic [DATA_WIDTH-1:0] alu_result_hi_po;
  logic                  carry_out_po;
  logic                  borrow_out_po;
`ifdef ALU_SEQ_ZN_FLAGS_EN
  logic                  zero_flag_po;
  logic                  negative_flag_po;
`endif
  // FSM state for observation: 0 = IDLE, 1 = MUL_RUN
  logic                  state_dbg;

  // ALU side
  modport slave (
    input  start_pi, op_class_pi, alu_func_pi,
    input  reg1_data_pi, reg2_data_pi, immediate_pi,
    output busy_po, done_po, alu_result_po, alu_result_hi_po,
    output carry_out_po, borrow_out_po,
`ifdef ALU_SEQ_ZN_FLAGS_EN
    output zero_flag_po, negative_flag_po,
`endif
    output state_dbg
  );

  // Issuing side
  modport master (
    output start_pi, op_class_pi, alu_func_pi,
    output reg1_data_pi, reg2_data_pi, immediate_pi,
    input  busy_po, done_po, alu_result_po, alu_result_hi_po,
    input  carry_out_po, borrow_out_po,
`ifdef ALU_SEQ_ZN_FLAGS_EN
    input  zero_flag_po, negative_flag_po,
`endif
    input  state_dbg
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with internal carry/borrow flags and an iterative
// shift-add multiplier (one partial product per cycle).
// Single-cycle ops update result/flags at the accepting edge; MUL runs for
// DATA_WIDTH cycles in MUL_RUN with busy_po high.
// Optional feature macro: ALU_SEQ_ZN_FLAGS_EN adds registered zero/negative
// flags that update on every done event.
module alu_seq #(
  parameter int DATA_WIDTH = 16,
  parameter int IMM_WIDTH  = 6
) (
  input  logic        clk_pi,
  input  logic        reset_pi,
  alu_seq_if.slave    bus
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(DATA_WIDTH - 1);

  localparam logic [2:0] OP_ARITH_2OP = 3'd0;
  localparam logic [2:0] OP_ARITH_1OP = 3'd1;
  localparam logic [2:0] OP_ADDI      = 3'd2;
  localparam logic [2:0] OP_SUBI      = 3'd3;
  localparam logic [2:0] OP_LDST      = 3'd4;
  localparam logic [2:0] OP_MUL       = 3'd5;
  localparam logic [2:0] OP_STC       = 3'd6;
  localparam logic [2:0] OP_STB       = 3'd7;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MUL_RUN = 1'b1
  } state_t;

  state_t state_q, state_d;

  // Architectural outputs
  logic [W-1:0] result_q;
  logic [W-1:0] result_hi_q;
  logic         carry_q;
  logic         borrow_q;
  logic         done_q;
`ifdef ALU_SEQ_ZN_FLAGS_EN
  logic         zero_q;
  logic         negative_q;
`endif

  // Multiplier engine
  logic [2*W-1:0] mcand_q;
  logic [W-1:0]   mplier_q;
  logic [2*W-1:0] acc_q;
  logic [2*W-1:0] acc_d;
  logic [CW-1:0]  count_q;

  // Control strobes from the FSM
  logic accept_sc;
  logic accept_mul;
  logic mul_last;

  // Single-cycle datapath results
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] imm_ext;
  logic [W:0]   wide;
  logic [W-1:0] sc_result;
  logic         sc_carry;
  logic         sc_borrow;

  assign a       = bus.reg1_data_pi;
  assign b       = bus.reg2_data_pi;
  assign imm_ext = {{(W-IMM_WIDTH){1'b0}}, bus.immediate_pi};

  // Next state and control strobes; start is only looked at in IDLE
  always_comb begin
    state_d    = state_q;
    accept_sc  = 1'b0;
    accept_mul = 1'b0;
    mul_last   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start_pi) begin
          if (bus.op_class_pi == OP_MUL) begin
            accept_mul = 1'b1;
            state_d    = MUL_RUN;
          end else begin
            accept_sc  = 1'b1;
          end
        end
      end
      MUL_RUN: begin
        if (count_q == LAST_ITER) begin
          mul_last = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_pi) begin
    if (reset_pi) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Single-cycle op results; flags default to their held values
  always_comb begin
    wide      = '0;
    sc_result = '0;
    sc_carry  = carry_q;
    sc_borrow = borrow_q;
    case (bus.op_class_pi)
      OP_ARITH_2OP: begin
        case (bus.alu_func_pi)
          3'b000: begin
            wide      = {1'b0, a} + {1'b0, b};
            sc_result = wide[W-1:0];
            sc_carry  = wide[W];
          end
          3'b001: begin
            wide      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, carry_q};
            sc_result = wide[W-1:0];
            sc_carry  = wide[W];
          end
          3'b010: begin
            // bit W of the (W+1)-bit difference is set exactly when A < B
            wide      = {1'b0, a} - {1'b0, b};
            sc_result = wide[W-1:0];
            sc_borrow = wide[W];
          end
          3'b011: begin
            wide      = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, borrow_q};
            sc_result = wide[W-1:0];
            sc_borrow = wide[W];
          end
          3'b100:  sc_result = a & b;
          3'b101:  sc_result = a | b;
          3'b110:  sc_result = a ^ b;
          default: sc_result = ~(a ^ b);
        endcase
      end
      OP_ARITH_1OP: begin
        case (bus.alu_func_pi)
          3'b000:  sc_result = ~a;
          3'b001:  sc_result = {a[W-2:0], 1'b0};
          3'b010:  sc_result = {1'b0, a[W-1:1]};
          3'b011:  sc_result = a;
          3'b100:  sc_result = {a[W-1], a[W-1:1]};
          3'b101:  sc_result = {a[W-2:0], a[W-1]};
          3'b110:  sc_result = {a[0], a[W-1:1]};
          default: sc_result = '0;
        endcase
      end
      OP_ADDI: begin
        wide      = {1'b0, a} + {1'b0, imm_ext};
        sc_result = wide[W-1:0];
        sc_carry  = wide[W];
      end
      OP_SUBI: begin
        wide      = {1'b0, a} - {1'b0, imm_ext};
        sc_result = wide[W-1:0];
        sc_borrow = wide[W];
      end
      OP_LDST: begin
        sc_result = a + imm_ext;
      end
      OP_STC: begin
        sc_result = '0;
        sc_carry  = 1'b1;
      end
      OP_STB: begin
        sc_result = '0;
        sc_borrow = 1'b1;
      end
      default: begin
        sc_result = '0;
      end
    endcase
  end

  // Accumulator plus the current partial product
  always_comb begin
    acc_d = acc_q;
    if (mplier_q[0]) begin
      acc_d = acc_q + mcand_q;
    end
  end

  // Multiplier operand shift registers and iteration counter
  always_ff @(posedge clk_pi) begin
    if (reset_pi) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
    end else if (accept_mul) begin
      mcand_q  <= {{W{1'b0}}, a};
      mplier_q <= b;
      acc_q    <= '0;
      count_q  <= '0;
    end else if (state_q == MUL_RUN) begin
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      acc_q    <= acc_d;
      count_q  <= count_q + CW'(1);
    end
  end

  // Result, flag and done registers; outputs hold between done events
  always_ff @(posedge clk_pi) begin
    if (reset_pi) begin
      result_q    <= '0;
      result_hi_q <= '0;
      carry_q     <= 1'b0;
      borrow_q    <= 1'b0;
      done_q      <= 1'b0;
`ifdef ALU_SEQ_ZN_FLAGS_EN
      zero_q      <= 1'b0;
      negative_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (accept_sc) begin
        result_q    <= sc_result;
        result_hi_q <= '0;
        carry_q     <= sc_carry;
        borrow_q    <= sc_borrow;
        done_q      <= 1'b1;
`ifdef ALU_SEQ_ZN_FLAGS_EN
        zero_q      <= (sc_result == '0);
        negative_q  <= sc_result[W-1];
`endif
      end else if (mul_last) begin
        result_q    <= acc_d[W-1:0];
        result_hi_q <= acc_d[2*W-1:W];
        done_q      <= 1'b1;
`ifdef ALU_SEQ_ZN_FLAGS_EN
        zero_q      <= (acc_d == '0);
        negative_q  <= acc_d[2*W-1];
`endif
      end
    end
  end

  assign bus.busy_po          = (state_q == MUL_RUN);
  assign bus.done_po          = done_q;
  assign bus.alu_result_po    = result_q;
  assign bus.alu_result_hi_po = result_hi_q;
  assign bus.carry_out_po     = carry_q;
  assign bus.borrow_out_po    = borrow_q;
  assign bus.state_dbg        = (state_q == MUL_RUN);
`ifdef ALU_SEQ_ZN_FLAGS_EN
  assign bus.zero_flag_po     = zero_q;
  assign bus.negative_flag_po = negative_q;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vector table, hand-written multi-cycle sequences and a
// randomized run checked against an arithmetic reference model.
module tb_alu_seq;
  localparam int W  = 16;
  localparam int IW = 6;

  logic clk;
  logic rst;

  int checks;
  int errors;

  bit m_carry;
  bit m_borrow;

  logic [2*W+1:0] exp_q[$];

  alu_seq_if #(.DATA_WIDTH(W), .IMM_WIDTH(IW)) bus ();

  alu_seq #(.DATA_WIDTH(W), .IMM_WIDTH(IW)) dut (
    .clk_pi  (clk),
    .reset_pi(rst),
    .bus     (bus)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]    op;
    logic [2:0]    fn;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [IW-1:0] imm;
    logic [W-1:0]  res;
    logic          c;
    logic          br;
    string         name;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [2:0] fn,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [IW-1:0] imm);
    bus.op_class_pi  = op;
    bus.alu_func_pi  = fn;
    bus.reg1_data_pi = a;
    bus.reg2_data_pi = b;
    bus.immediate_pi = imm;
  endtask

  // Present one op for one edge; returns at the falling edge after it
  task automatic issue(input logic [2:0] op, input logic [2:0] fn,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [IW-1:0] imm);
    @(negedge clk);
    drive(op, fn, a, b, imm);
    bus.start_pi = 1'b1;
    @(negedge clk);
    bus.start_pi = 1'b0;
    drive(3'd0, 3'd0, $urandom_range(0, 65535), $urandom_range(0, 65535), '0);
  endtask

  task automatic wait_done(output bit ok);
    int n;
    n = 0;
    while (bus.done_po !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    ok = (bus.done_po === 1'b1);
  endtask

  // Reference model: plain integer arithmetic on the op definitions
  task automatic model(input logic [2:0] op, input logic [2:0] fn,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [IW-1:0] imm,
                       output logic [W-1:0] res, output logic [W-1:0] hi);
    longint av, bv, iv, t, lim;
    av  = longint'(a);
    bv  = longint'(b);
    iv  = longint'(imm);
    lim = 65535;
    t   = 0;
    hi  = '0;
    case (op)
      3'd0: case (fn)
        3'd0: begin t = av + bv; m_carry = (t > lim); end
        3'd1: begin t = av + bv + longint'(m_carry); m_carry = (t > lim); end
        3'd2: begin t = av - bv; m_borrow = (t < 0); end
        3'd3: begin t = av - bv - longint'(m_borrow); m_borrow = (t < 0); end
        3'd4: t = av & bv;
        3'd5: t = av | bv;
        3'd6: t = av ^ bv;
        default: t = ~(av ^ bv);
      endcase
      3'd1: case (fn)
        3'd0: t = ~av;
        3'd1: t = av * 2;
        3'd2: t = av / 2;
        3'd3: t = av;
        3'd4: t = av / 2 + ((av >= 32768) ? 32768 : 0);
        3'd5: t = av * 2 + av / 32768;
        3'd6: t = av / 2 + (av % 2) * 32768;
        default: t = 0;
      endcase
      3'd2: begin t = av + iv; m_carry = (t > lim); end
      3'd3: begin t = av - iv; m_borrow = (t < 0); end
      3'd4: t = av + iv;
      3'd5: begin t = av * bv; hi = t[31:16]; end
      3'd6: begin t = 0; m_carry = 1'b1; end
      default: begin t = 0; m_borrow = 1'b1; end
    endcase
    res = t[15:0];
  endtask

  initial begin
    bit            ok;
    int            busy_cnt;
    logic [2:0]    op, fn;
    logic [W-1:0]  ra, rb, eres, ehi;
    logic [IW-1:0] rimm;
    logic [2*W+1:0] e;

    checks = 0;
    errors = 0;

    // Directed vectors; flags chain from one entry to the next
    vecs[0]  = '{3'd0, 3'd0, 16'hFFFF, 16'h0001, 6'h00, 16'h0000, 1'b1, 1'b0, "add_carry"};
    vecs[1]  = '{3'd0, 3'd1, 16'h0001, 16'h0001, 6'h00, 16'h0003, 1'b0, 1'b0, "addc"};
    vecs[2]  = '{3'd0, 3'd2, 16'h0000, 16'h0001, 6'h00, 16'hFFFF, 1'b0, 1'b1, "sub_borrow"};
    vecs[3]  = '{3'd0, 3'd3, 16'h0005, 16'h0001, 6'h00, 16'h0003, 1'b0, 1'b0, "subb"};
    vecs[4]  = '{3'd3, 3'd0, 16'h0010, 16'h0000, 6'h3F, 16'hFFD1, 1'b0, 1'b1, "subi"};
    vecs[5]  = '{3'd6, 3'd0, 16'h1111, 16'h2222, 6'h05, 16'h0000, 1'b1, 1'b1, "stc"};
    vecs[6]  = '{3'd0, 3'd4, 16'h00F0, 16'h0FF0, 6'h00, 16'h00F0, 1'b1, 1'b1, "and"};
    vecs[7]  = '{3'd1, 3'd4, 16'h8002, 16'h0000, 6'h00, 16'hC001, 1'b1, 1'b1, "asr"};
    vecs[8]  = '{3'd1, 3'd6, 16'h0001, 16'h0000, 6'h00, 16'h8000, 1'b1, 1'b1, "ror"};
    vecs[9]  = '{3'd0, 3'd7, 16'hA5A5, 16'h0F0F, 6'h00, 16'h5555, 1'b1, 1'b1, "xnor"};
    vecs[10] = '{3'd1, 3'd7, 16'h1234, 16'h0000, 6'h00, 16'h0000, 1'b1, 1'b1, "rsvd_1op"};
    vecs[11] = '{3'd2, 3'd0, 16'h0010, 16'h0000, 6'h3F, 16'h004F, 1'b0, 1'b1, "addi"};
    vecs[12] = '{3'd0, 3'd2, 16'h0005, 16'h0003, 6'h00, 16'h0002, 1'b0, 1'b0, "sub_nob"};
    vecs[13] = '{3'd7, 3'd0, 16'hFFFF, 16'hFFFF, 6'h00, 16'h0000, 1'b0, 1'b1, "stb"};
    vecs[14] = '{3'd4, 3'd0, 16'h0100, 16'h0000, 6'h04, 16'h0104, 1'b0, 1'b1, "ldst"};
    vecs[15] = '{3'd1, 3'd5, 16'h8001, 16'h0000, 6'h00, 16'h0003, 1'b0, 1'b1, "rol"};
    vecs[16] = '{3'd1, 3'd1, 16'h8001, 16'h0000, 6'h00, 16'h0002, 1'b0, 1'b1, "shl"};
    vecs[17] = '{3'd1, 3'd2, 16'h8001, 16'h0000, 6'h00, 16'h4000, 1'b0, 1'b1, "shr"};
    vecs[18] = '{3'd1, 3'd0, 16'h00FF, 16'h0000, 6'h00, 16'hFF00, 1'b0, 1'b1, "not"};
    vecs[19] = '{3'd1, 3'd3, 16'h1234, 16'h0000, 6'h00, 16'h1234, 1'b0, 1'b1, "cp"};

    // Reset
    rst = 1'b1;
    bus.start_pi = 1'b0;
    drive(3'd0, 3'd0, '0, '0, '0);
    repeat (3) @(negedge clk);
    check("rst_result", bus.alu_result_po, 16'h0000);
    check("rst_hi", bus.alu_result_hi_po, 16'h0000);
    check("rst_busy", bus.busy_po, 1'b0);
    check("rst_done", bus.done_po, 1'b0);
    check("rst_carry", bus.carry_out_po, 1'b0);
    check("rst_borrow", bus.borrow_out_po, 1'b0);
`ifdef ALU_SEQ_ZN_FLAGS_EN
    check("rst_zero", bus.zero_flag_po, 1'b0);
    check("rst_neg", bus.negative_flag_po, 1'b0);
`endif
    rst = 1'b0;

    // Vector table
    for (int i = 0; i < 20; i++) begin
      issue(vecs[i].op, vecs[i].fn, vecs[i].a, vecs[i].b, vecs[i].imm);
      check({"vec_done_", vecs[i].name}, bus.done_po, 1'b1);
      check({"vec_res_", vecs[i].name}, bus.alu_result_po, vecs[i].res);
      check({"vec_hi_", vecs[i].name}, bus.alu_result_hi_po, 16'h0000);
      check({"vec_carry_", vecs[i].name}, bus.carry_out_po, vecs[i].c);
      check({"vec_borrow_", vecs[i].name}, bus.borrow_out_po, vecs[i].br);
    end
    @(negedge clk);
    check("done_one_cycle", bus.done_po, 1'b0);
    m_carry  = 1'b0;
    m_borrow = 1'b1;

    // MUL 0x1234*0x0010, ignored ADD while busy, back-to-back ADD on done
    issue(3'd5, 3'd0, 16'h1234, 16'h0010, 6'h00);
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done_po === 1'b1) break;
      if (bus.busy_po === 1'b1) busy_cnt++;
      if (busy_cnt == 3) begin
        drive(3'd0, 3'd0, 16'hFFFF, 16'h0001, 6'h00);
        bus.start_pi = 1'b1;
      end else begin
        bus.start_pi = 1'b0;
      end
      if (busy_cnt == 5) begin
        check("mul_hold_res", bus.alu_result_po, 16'h1234);
        check("mul_state_dbg", bus.state_dbg, 1'b1);
      end
      @(negedge clk);
    end
    bus.start_pi = 1'b0;
    check("mul1_done", bus.done_po, 1'b1);
    check("mul1_busy_cycles", busy_cnt, 16);
    check("mul1_busy_low", bus.busy_po, 1'b0);
    check("mul1_lo", bus.alu_result_po, 16'h2340);
    check("mul1_hi", bus.alu_result_hi_po, 16'h0001);
    check("mul1_carry", bus.carry_out_po, 1'b0);
    check("mul1_borrow", bus.borrow_out_po, 1'b1);
    drive(3'd0, 3'd0, 16'h0002, 16'h0003, 6'h00);
    bus.start_pi = 1'b1;
    @(negedge clk);
    bus.start_pi = 1'b0;
    check("b2b_done", bus.done_po, 1'b1);
    check("b2b_res", bus.alu_result_po, 16'h0005);
    check("b2b_hi", bus.alu_result_hi_po, 16'h0000);
    check("b2b_carry", bus.carry_out_po, 1'b0);

    // MUL max operands, then LOAD/STORE clears the high half
    issue(3'd5, 3'd0, 16'hFFFF, 16'hFFFF, 6'h00);
    wait_done(ok);
    check("mul2_done", ok, 1'b1);
    check("mul2_lo", bus.alu_result_po, 16'h0001);
    check("mul2_hi", bus.alu_result_hi_po, 16'hFFFE);
    check("mul2_carry", bus.carry_out_po, 1'b0);
    check("mul2_borrow", bus.borrow_out_po, 1'b1);
    issue(3'd4, 3'd0, 16'h0100, 16'h0000, 6'h04);
    check("ldst_res", bus.alu_result_po, 16'h0104);
    check("ldst_hi", bus.alu_result_hi_po, 16'h0000);

    // Reset on the 5th busy cycle aborts MUL; start with reset is ignored
    issue(3'd6, 3'd0, 16'h0000, 16'h0000, 6'h00);
    issue(3'd1, 3'd3, 16'hBEEF, 16'h0000, 6'h00);
    issue(3'd5, 3'd0, 16'h00FF, 16'h0101, 6'h00);
    busy_cnt = 1;
    while (busy_cnt < 5) begin
      @(negedge clk);
      busy_cnt++;
    end
    check("abort_busy_before", bus.busy_po, 1'b1);
    rst = 1'b1;
    drive(3'd0, 3'd0, 16'h0001, 16'h0001, 6'h00);
    bus.start_pi = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.start_pi = 1'b0;
    check("abort_busy", bus.busy_po, 1'b0);
    check("abort_done", bus.done_po, 1'b0);
    check("abort_res", bus.alu_result_po, 16'h0000);
    check("abort_hi", bus.alu_result_hi_po, 16'h0000);
    check("abort_carry", bus.carry_out_po, 1'b0);
    check("abort_borrow", bus.borrow_out_po, 1'b0);
    @(negedge clk);
    check("abort_no_done", bus.done_po, 1'b0);
    check("abort_idle", bus.busy_po, 1'b0);
    m_carry  = 1'b0;
    m_borrow = 1'b0;

    // Randomized ops against the reference model
    for (int n = 0; n < 150; n++) begin
      op = 3'($urandom_range(0, 7));
      if (op == 3'd5 && $urandom_range(0, 3) != 0) op = 3'd0;
      fn   = 3'($urandom_range(0, 7));
      ra   = 16'($urandom_range(0, 65535));
      rb   = 16'($urandom_range(0, 65535));
      rimm = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) ra = 16'hFFFF;
      if ($urandom_range(0, 7) == 0) rb = 16'h0000;
      model(op, fn, ra, rb, rimm, eres, ehi);
      exp_q.push_back({ehi, eres, m_carry, m_borrow});
      issue(op, fn, ra, rb, rimm);
      wait_done(ok);
      check("rnd_done", ok, 1'b1);
      e = exp_q.pop_front();
      check("rnd_res", bus.alu_result_po, e[W+1:2]);
      check("rnd_hi", bus.alu_result_hi_po, e[2*W+1:W+2]);
      check("rnd_carry", bus.carry_out_po, e[1]);
      check("rnd_borrow", bus.borrow_out_po, e[0]);
`ifdef ALU_SEQ_ZN_FLAGS_EN
      check("rnd_zero", bus.zero_flag_po, (e[2*W+1:2] == '0));
      check("rnd_neg", bus.negative_flag_po, (op == 3'd5) ? e[2*W+1] : e[W+1]);
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
